// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and a width helper.
// The matching uart_tx is meant to reuse this package.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Bits needed to count from 0 to value-1, never less than one.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's tick, serial line and result signals.
// master drives tick/rx and observes results; slave is the receiver side.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);

    logic               tick;
    logic               rx;
    logic [NB_DATA-1:0] data;
    logic               rx_done;
    logic               frame_err;

    modport master (
        output tick,
        output rx,
        input  data,
        input  rx_done,
        input  frame_err
    );

    modport slave (
        input  tick,
        input  rx,
        output data,
        output rx_done,
        output frame_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to idle-high.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, data
// sampled at bit centres, stop bit checked for framing errors.
module uart_rx #(
    parameter int NB_DATA      = 8,
    parameter int OVERSAMPLING = 16,
    parameter int SB_TICK      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err
);

    import uart_pkg::*;

    localparam int S_MAX = (OVERSAMPLING > SB_TICK) ? OVERSAMPLING : SB_TICK;
    localparam int S_W   = clogb2(S_MAX);
    localparam int N_W   = clogb2(NB_DATA);

    localparam logic [S_W-1:0] S_ONE      = S_W'(1);
    localparam logic [S_W-1:0] START_LAST = S_W'(OVERSAMPLING / 2 - 1);
    localparam logic [S_W-1:0] DATA_LAST  = S_W'(OVERSAMPLING - 1);
    localparam logic [S_W-1:0] STOP_LAST  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_ONE      = N_W'(1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(NB_DATA - 1);

    logic               rx_s;
    logic [1:0]         state;
    logic [S_W-1:0]     s_cnt;
    logic [N_W-1:0]     n_cnt;
    logic [NB_DATA-1:0] b_reg;

    sync_2ff u_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    // Pulses default low every cycle so each lasts exactly one clock; o_data
    // is loaded only alongside o_rx_done, so bad frames never disturb it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            s_cnt       <= '0;
            n_cnt       <= '0;
            b_reg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        s_cnt <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s_cnt == START_LAST) begin
                            if (!rx_s) begin
                                s_cnt <= '0;
                                n_cnt <= '0;
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s_cnt == DATA_LAST) begin
                            s_cnt <= '0;
                            b_reg <= {rx_s, b_reg[NB_DATA-1:1]};
                            if (n_cnt == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n_cnt <= n_cnt + N_ONE;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_ONE;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (s_cnt == STOP_LAST) begin
                            state <= IDLE;
                            if (rx_s) begin
                                o_rx_done <= 1'b1;
                                o_data    <= b_reg;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level model of the expected receiver results.
`timescale 1ns/1ps
module tb_uart_rx;

    // 50 MHz clock; the tick divider is shortened from 163 (19200 baud x16)
    // so that the whole run stays within a small cycle budget.
    localparam int CLK_NS   = 20;
    localparam int TICK_DIV = 5;
    localparam int BIT_NS   = 16 * TICK_DIV * CLK_NS;

    logic clk;
    logic rst_n;
    int   div_cnt;

    uart_rx_if #(.NB_DATA(8)) bus ();

    uart_rx #(
        .NB_DATA      (8),
        .OVERSAMPLING (16),
        .SB_TICK      (16)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_tick      (bus.tick),
        .i_rx        (bus.rx),
        .o_data      (bus.data),
        .o_rx_done   (bus.rx_done),
        .o_frame_err (bus.frame_err)
    );

    int         checks;
    int         errors;
    int         done_cnt;
    int         err_cnt;
    logic [7:0] got_q[$];
    logic [7:0] model_data;
    logic       prev_pulse;

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Baud-rate generator: one-clock tick every TICK_DIV clocks.
    initial begin
        div_cnt  = 0;
        bus.tick = 1'b0;
    end
    always @(posedge clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt  <= 0;
            bus.tick <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1;
            bus.tick <= 1'b0;
        end
    end

    // Output monitor: counts pulses, records received bytes, and checks that
    // pulses are single-cycle and never coincide.
    initial prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (bus.rx_done) begin
            done_cnt++;
            got_q.push_back(bus.data);
        end
        if (bus.frame_err) err_cnt++;
        if (bus.rx_done || bus.frame_err) begin
            checks++;
            if ((bus.rx_done && bus.frame_err) || prev_pulse) begin
                errors++;
                $display("[TB] FAIL pulse_shape got done=%0b err=%0b prev=%0b want single isolated pulse",
                         bus.rx_done, bus.frame_err, prev_pulse);
            end
        end
        prev_pulse = bus.rx_done || bus.frame_err;
    end

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bit_ns);
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        if (stop_ok) begin
            bus.rx = 1'b1;
            #(bit_ns);
        end else begin
            bus.rx = 1'b0;
            #(bit_ns * 3 / 4);
            bus.rx = 1'b1;
            #(bit_ns / 4);
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 00", bus.data);
        end
        checks++;
        if (bus.rx_done !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses got done=%0b err=%0b want 0 0", bus.rx_done, bus.frame_err);
        end
        rst_n = 1'b1;
        model_data = 8'h00;
        #(BIT_NS);
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL reset_idle got done=%0d err=%0d want 0 0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_single;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h55, 1'b1, BIT_NS);
        model_data = 8'h55;
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL single_counts got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL single_data got %h want %h", bus.data, model_data);
        end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        send_frame(8'hA3, 1'b1, BIT_NS);
        send_frame(8'h0F, 1'b1, BIT_NS);
        model_data = 8'h0F;
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want 2", done_cnt - d0);
        end
        checks++;
        if (got_q[$-1] !== 8'hA3 || got_q[$] !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL b2b_data got %h %h want a3 0f", got_q[$-1], got_q[$]);
        end
        checks++;
        if (bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL b2b_final got %h want %h", bus.data, model_data);
        end
    endtask

    task automatic test_glitch;
        int d0 = done_cnt;
        int e0 = err_cnt;
        bus.rx = 1'b0;
        #(4 * TICK_DIV * CLK_NS);
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_reject got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_frame(8'h3C, 1'b1, BIT_NS);
        model_data = 8'h3C;
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 1 || bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL glitch_next got done=%0d data=%h want 1 %h", done_cnt - d0, bus.data, model_data);
        end
    endtask

    task automatic test_frame_err;
        int d0 = done_cnt;
        int e0 = err_cnt;
        send_frame(8'h81, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL ferr_counts got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL ferr_hold got %h want %h", bus.data, model_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0 = done_cnt;
        int e0 = err_cnt;
        bus.rx = 1'b0;
        #(BIT_NS);
        bus.rx = 1'b1;
        #(4 * BIT_NS + BIT_NS / 2);
        @(negedge clk);
        rst_n = 1'b0;
        model_data = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #(8 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_pulses got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (bus.data !== model_data || bus.rx_done !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got data=%h done=%0b err=%0b want 00 0 0",
                     bus.data, bus.rx_done, bus.frame_err);
        end
        send_frame(8'h12, 1'b1, BIT_NS);
        model_data = 8'h12;
        #(2 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 1 || bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL midreset_next got done=%0d data=%h want 1 %h", done_cnt - d0, bus.data, model_data);
        end
    endtask

    task automatic test_skew;
        int rates[2] = '{BIT_NS * 103 / 100, BIT_NS * 97 / 100};
        for (int k = 0; k < 2; k++) begin
            int d0 = done_cnt;
            int e0 = err_cnt;
            send_frame(8'hC6, 1'b1, rates[k]);
            model_data = 8'hC6;
            #(2 * BIT_NS);
            checks++;
            if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || bus.data !== model_data) begin
                errors++;
                $display("[TB] FAIL skew_%0d got done=%0d err=%0d data=%h want 1 0 %h",
                         k, done_cnt - d0, err_cnt - e0, bus.data, model_data);
            end
        end
    endtask

    // A held-low line repeats a 9.5-bit frame cycle; releasing it a quarter
    // bit into the fourth attempt lets that attempt die as a glitch.
    task automatic test_break;
        int d0 = done_cnt;
        int e0 = err_cnt;
        bus.rx = 1'b0;
        #(28 * BIT_NS + 3 * BIT_NS / 4);
        bus.rx = 1'b1;
        #(3 * BIT_NS);
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 3) begin
            errors++;
            $display("[TB] FAIL break_counts got done=%0d err=%0d want 0 3", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (bus.data !== model_data) begin
            errors++;
            $display("[TB] FAIL break_hold got %h want %h", bus.data, model_data);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            bit         ok;
            int         bit_ns;
            int         d0;
            int         e0;
            b      = 8'($urandom_range(0, 255));
            ok     = ($urandom_range(0, 3) != 0);
            bit_ns = BIT_NS * (99 + int'($urandom_range(0, 2))) / 100;
            d0     = done_cnt;
            e0     = err_cnt;
            send_frame(b, ok, bit_ns);
            if (ok) model_data = b;
            #(BIT_NS * (1 + int'($urandom_range(0, 1))));
            checks++;
            if (done_cnt - d0 !== (ok ? 1 : 0) || err_cnt - e0 !== (ok ? 0 : 1)) begin
                errors++;
                $display("[TB] FAIL rand_%0d_counts got done=%0d err=%0d want %0d %0d",
                         n, done_cnt - d0, err_cnt - e0, ok ? 1 : 0, ok ? 0 : 1);
            end
            checks++;
            if (bus.data !== model_data) begin
                errors++;
                $display("[TB] FAIL rand_%0d_data got %h want %h", n, bus.data, model_data);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        err_cnt  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_skew();
        test_break();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLING, default 16, sample ticks per bit period.
REQ-003 SHALL have parameter SB_TICK, default 16, ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-004 SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_tick  input  1  one-cycle oversampling strobe from the baud-rate generator, OVERSAMPLING per bit.
REQ-007 SHALL have port i_rx  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port o_data  output  NB_DATA  last received byte, LSB = first bit received.
REQ-009 SHALL have port o_rx_done  output  1  one-clock pulse when a frame with a valid stop bit completes.
REQ-010 SHALL have port o_frame_err  output  1  one-clock pulse when the stop bit samples low.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized line rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, with tick counter s_cnt (width clog2(max(OVERSAMPLING,SB_TICK))) and bit counter n_cnt (width clog2(NB_DATA)).
REQ-013 SHALL, in IDLE, on any clock with rx_s = 0, clear s_cnt and enter START (no tick required).
REQ-014 SHALL, in START, on the tick where s_cnt = OVERSAMPLING/2-1, go to DATA with s_cnt = 0 and n_cnt = 0 if rx_s = 0, else return to IDLE (glitch rejected, no outputs asserted).
REQ-015 SHALL, in DATA, on the tick where s_cnt = OVERSAMPLING-1, clear s_cnt and shift rx_s into the MSB of the shift register (right shift); after the NB_DATA-th sample, go to STOP.
REQ-016 SHALL, in STOP, on the tick where s_cnt = SB_TICK-1, return to IDLE and pulse o_rx_done if rx_s = 1, else pulse o_frame_err.
REQ-017 SHALL increment s_cnt only on clocks with i_tick = 1; between ticks all state holds.
REQ-018 SHALL update o_data from the shift register in the same cycle o_rx_done asserts, and hold it until the next good frame; a framing-error frame SHALL NOT update o_data.
REQ-019 SHALL never assert o_rx_done and o_frame_err in the same cycle; each is high for exactly one i_clk cycle per frame.
REQ-020 SHALL, when returning to IDLE from STOP with rx_s already low, start the next frame on the following clock (back-to-back frames, no lost frame).
REQ-021 SHALL ignore i_tick in IDLE; a permanently low line after a framing error SHALL re-enter START and repeat (break condition yields repeated o_frame_err, no o_rx_done).
REQ-022 SHALL make latency from stop-bit sample tick to o_rx_done exactly one i_clk cycle (registered outputs).

Reset
REQ-023 SHALL, on i_reset_n = 0, asynchronously set state = IDLE, s_cnt = 0, n_cnt = 0, shift register = 0, o_data = 0, o_rx_done = 0, o_frame_err = 0, synchronizer flops = 1.
REQ-024 SHALL, on reset asserted mid-frame, abandon the frame without any output pulse; after release, resume in IDLE and wait for a fresh falling edge.

Structure
REQ-025 SHALL take the FSM state encodings (2-bit: IDLE=0, START=1, DATA=2, STOP=3) and the clogb2 function from the shared uart_pkg, reused by the later uart_tx.
REQ-026 SHALL instantiate one sub-module, sync_2ff, for the i_rx synchronizer; everything else is in uart_rx.

Verification
REQ-027 SHALL cover: 50 MHz clock, baudRateGen at 19200/16 driving i_tick, frame 0x55 with 1 stop bit -> single o_rx_done pulse, o_data = 0x55, o_frame_err never high.
REQ-028 SHALL cover: 0xA3 followed immediately by 0x0F with no idle gap -> two o_rx_done pulses, o_data = 0xA3 then 0x0F.
REQ-029 SHALL cover: low glitch on i_rx lasting 4 tick periods in IDLE -> FSM returns to IDLE, no o_rx_done or o_frame_err, next valid 0x3C received correctly.
REQ-030 SHALL cover: frame 0x81 with stop bit forced low -> one o_frame_err pulse, no o_rx_done, o_data keeps previous value.
REQ-031 SHALL cover: i_reset_n pulsed low during DATA bit 4 of frame 0xFF -> no output pulses, all outputs 0, next frame 0x12 received as 0x12.
REQ-032 SHALL cover: bit timing skewed +/-3% from nominal baud on frame 0xC6 -> o_data = 0xC6 with one o_rx_done.
